piso_rshift: RTL and testbench
==============================

Name: piso_rshift

Overview:
- Parallel-in, serial-out right-shift register with valid/ready handshakes on both sides.
- Accepts a WIDTH-bit word and emits it LSB first, one bit per accepted transfer.
- Each accepted bit shifts the register right by one; a programmable fill bit enters at the MSB.
- Serves as the transmit-side serializer for the datapath's left-shift/deserialize logic, so words cross a 1-bit link.

Parameters:
- WIDTH, 8, word width in bits. Legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH), bit counter width. Derived value; do not override.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  parallel word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  parallel word to serialize.
- fill_bit  input  1  value shifted into the MSB on each shift; sampled with in_data at load.
- ser_out  output  1  current serial bit, equal to shreg[0].
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  downstream accepts ser_out this cycle.
- shreg_q  output  WIDTH  live shift-register contents, for debug/parallel view.
- busy  output  1  word in progress.
- done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset is synchronous: on a clk edge with rst=1, the block enters state IDLE.
  - Reset values: shreg_q=0, cnt=0, fill register=0, done=0.
  - Resulting outputs: ser_valid=0, in_ready=1, busy=0.
  - rst has priority over every other event, including a mid-word reset. The partial word is discarded, no done pulse is produced, and no bits are emitted the following cycle.
- State IDLE:
  - in_ready=1, ser_valid=0, busy=0.
  - On in_valid=1 at a clk edge: shreg <= in_data, fill <= fill_bit, cnt <= 0, go to SHIFT.
- State SHIFT:
  - in_ready=0, ser_valid=1, busy=1, ser_out=shreg[0].
  - in_valid is ignored and in_data is not sampled.
  - On ser_ready=1 at a clk edge: shreg <= {fill, shreg[WIDTH-1:1]} and cnt <= cnt+1.
    - If cnt==WIDTH-1, go to IDLE and set done=1 for exactly the next cycle.
  - On ser_ready=0: shreg, cnt and ser_out hold; stalls have no length limit.
- Latency:
  - The first bit appears the cycle after the load edge.
  - With no stalls, WIDTH bits occupy WIDTH consecutive cycles.
  - done rises in the cycle after the final accepted bit.
- Back-to-back words: exactly one IDLE cycle (in_ready=1) separates words. This bubble is fixed behaviour.
- After a complete word, shreg_q equals WIDTH copies of the fill bit.
- Outputs ser_out, ser_valid, in_ready and busy are decoded from registered state only; there is no combinational input-to-output path.
- Counter: unsigned CNT_W bits, compared against WIDTH-1. It never wraps within a word.

Decomposition:
- Shared package holds:
  - state enum: IDLE=1'b0, SHIFT=1'b1;
  - the constant for the default WIDTH.
- The shift datapath (shreg plus fill) is natural as one sub-module, rshift_stage: load/shift enable, right shift by one with MSB fill.
- The FSM and counter stay in the top module.

Test Plan:
- Load 8'hB4, fill_bit=0, ser_ready held 1 -> ser_out sequence 0,0,1,0,1,1,0,1 on cycles 1-8; done=1 on cycle 9; shreg_q=8'h00; in_ready=1 on cycle 9.
- Load 8'h01, fill_bit=1 -> ser_out 1,0,0,0,0,0,0,0; shreg_q after bit 1 = 8'h80; final shreg_q=8'hFF.
- Load 8'hB4, drop ser_ready for 3 cycles after bit 2 -> ser_out holds 1 and shreg_q holds 8'h2D during the stall; done on cycle 12; bit order unchanged.
- During SHIFT of 8'hB4, drive in_valid=1 with in_data=8'hFF -> in_ready stays 0; emitted bits remain those of 8'hB4.
- Assert rst after 4 bits of 8'hB4 -> next cycle ser_valid=0, busy=0, shreg_q=0, in_ready=1; no done pulse.
- Words 8'hA5 then 8'h3C with in_valid held -> 8 bits, one IDLE cycle, then 8 bits; two done pulses 9 cycles apart.

Source files
------------

// File: rtl/piso_rshift_pkg.sv
// Shared types and constants for the piso_rshift serializer.
package piso_rshift_pkg;

    // Default word width for the serializer and its interface.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states: waiting for a word, or emitting its bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : piso_rshift_pkg

// File: rtl/piso_rshift_if.sv
// Handshake bundle for piso_rshift: parallel input side and serial output side.
interface piso_rshift_if import piso_rshift_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             fill_bit;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;

    // Serializer side: consumes words, produces the bit stream.
    modport slave (
        input  in_valid,
        input  in_data,
        input  fill_bit,
        input  ser_ready,
        output in_ready,
        output ser_out,
        output ser_valid
    );

    // Environment side: offers words and accepts bits.
    modport master (
        output in_valid,
        output in_data,
        output fill_bit,
        output ser_ready,
        input  in_ready,
        input  ser_out,
        input  ser_valid
    );

endinterface : piso_rshift_if

// File: rtl/piso_rshift_stage.sv
// Shift datapath: loads a word plus its fill bit, then shifts right by one
// per enable with the captured fill bit entering at the MSB.
module rshift_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_fill,
    output logic [WIDTH-1:0] shreg_q
);

    logic [WIDTH-1:0] shreg_r;
    logic             fill_r;

    // Shift register and fill bit; load wins over shift, reset wins over both.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= {WIDTH{1'b0}};
            fill_r  <= 1'b0;
        end else if (load) begin
            shreg_r <= load_data;
            fill_r  <= load_fill;
        end else if (shift) begin
            shreg_r <= {fill_r, shreg_r[WIDTH-1:1]};
            fill_r  <= fill_r;
        end else begin
            shreg_r <= shreg_r;
            fill_r  <= fill_r;
        end
    end

    assign shreg_q = shreg_r;

endmodule : rshift_stage

// File: rtl/piso_rshift.sv
// Parallel-in serial-out right-shift serializer, LSB first, with valid/ready
// on both sides. Control FSM and bit counter live here; the datapath is in
// rshift_stage. All handshake outputs decode from registered state only.
module piso_rshift import piso_rshift_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    piso_rshift_if.slave     bus,
    output logic [WIDTH-1:0] shreg_q,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;
    logic             load_s;
    logic             shift_s;
    logic [WIDTH-1:0] shreg_s;

    // A word is captured only in IDLE; a bit is consumed only in SHIFT.
    assign load_s  = (state_r == IDLE)  && bus.in_valid;
    assign shift_s = (state_r == SHIFT) && bus.ser_ready;

    // Controller: state, bit counter and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bus.ser_ready) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_CNT) begin
                            state_r <= IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    rshift_stage #(
        .WIDTH(WIDTH)
    ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .shift     (shift_s),
        .load_data (bus.in_data),
        .load_fill (bus.fill_bit),
        .shreg_q   (shreg_s)
    );

    assign shreg_q       = shreg_s;
    assign bus.ser_out   = shreg_s[0];
    assign bus.ser_valid = (state_r == SHIFT);
    assign bus.in_ready  = (state_r == IDLE);
    assign busy          = (state_r == SHIFT);
    assign done          = done_r;

endmodule : piso_rshift

// File: tb/tb_piso_rshift.sv
// Self-checking bench for piso_rshift: directed scenarios followed by random
// traffic, every cycle compared against a word-level reference model.
module tb_piso_rshift;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] shreg_q;
    logic         busy;
    logic         done;

    piso_rshift_if #(.WIDTH(W)) bus_if ();

    piso_rshift #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .shreg_q (shreg_q),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the word being serialized, its fill bit, how many bits
    // have been accepted, and whether a done pulse is due this cycle.
    logic [W-1:0] m_word;
    logic         m_fill;
    int           m_k;
    logic         m_busy;
    logic         m_done;
    int           done_cycle[$];
    int           cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Register contents after k shifts: the word moved down k places with the
    // fill bit occupying the vacated top k positions.
    function automatic logic [W-1:0] model_shreg();
        logic [W-1:0] v;
        v = (m_k >= W) ? {W{1'b0}} : (m_word >> m_k);
        for (int i = 0; i < m_k && i < W; i++) v[W-1-i] = m_fill;
        return v;
    endfunction

    task automatic model_reset();
        m_word = {W{1'b0}};
        m_fill = 1'b0;
        m_k    = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    // One cycle: drive inputs away from the edge, compare outputs, then
    // advance the model by what the active edge does with those inputs.
    task automatic step(input logic v, input logic [W-1:0] d, input logic f,
                        input logic r, input logic rs);
        logic [W-1:0] exp_sh;
        @(negedge clk);
        bus_if.in_valid  = v;
        bus_if.in_data   = d;
        bus_if.fill_bit  = f;
        bus_if.ser_ready = r;
        rst              = rs;
        exp_sh = model_shreg();
        check("in_ready",  {31'd0, bus_if.in_ready},  {31'd0, ~m_busy});
        check("ser_valid", {31'd0, bus_if.ser_valid}, {31'd0, m_busy});
        check("busy",      {31'd0, busy},             {31'd0, m_busy});
        check("done",      {31'd0, done},             {31'd0, m_done});
        check("shreg_q",   {24'd0, shreg_q},          {24'd0, exp_sh});
        if (m_busy)
            check("ser_bit", {31'd0, bus_if.ser_out}, {31'd0, m_word[m_k]});
        else
            check("ser_idle", {31'd0, bus_if.ser_out}, {31'd0, exp_sh[0]});
        if (m_done) done_cycle.push_back(cyc);
        @(posedge clk);
        cyc++;
        if (rs) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (v) begin
                    m_word = d;
                    m_fill = f;
                    m_k    = 0;
                    m_busy = 1'b1;
                end
            end else if (r) begin
                m_k++;
                if (m_k == W) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        cyc = 0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = {W{1'b0}};
        bus_if.fill_bit  = 1'b0;
        bus_if.ser_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        model_reset();

        // Reset state, then 8'hB4 with fill 0 and ser_ready held high.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hB4, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("b4_final_shreg", {24'd0, shreg_q}, 32'h0000_0000);

        // 8'h01 with fill 1: register ends as all ones.
        step(1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("fill1_final_shreg", {24'd0, shreg_q}, 32'h0000_00FF);

        // 8'hB4 with a 3-cycle stall after bit 2, and in_valid/8'hFF offered mid-word.
        step(1'b1, 8'hB4, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        check("stall_shreg", {24'd0, shreg_q}, 32'h0000_002D);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset after 4 bits: no done pulse, register cleared.
        step(1'b1, 8'hB4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Back-to-back words with in_valid held: done pulses 9 cycles apart.
        done_cycle.delete();
        step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("b2b_done_count", done_cycle.size(), 32'd2);
        if (done_cycle.size() == 2)
            check("b2b_done_gap", done_cycle[1] - done_cycle[0], 32'd9);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1,
                 W'($urandom),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piso_rshift
